// File: rtl/neuron_lane_mac.sv
// Purpose: one neuron of a layer array. Computes a fixed-point dot product of a WEIGHT_NUM-element
//          input vector against a loadable weight RAM, LANES elements per beat. It then adds a bias,
//          saturates the sum and applies the selected activation.
// Ports:   in_data/in_valid/in_ready carry the input beat stream.
//          weight_*/bias_* with config_layer_num/config_neuron_num load the weights and bias.
//          out_data/out_valid/out_ready carry the result. busy marks a vector in flight.
// Latency: out_valid rises 4 cycles after the last beat is accepted. in_ready is low from the
//          last beat until the output handshake. The result is held while out_ready is low.
module neuron_lane_mac #(
    parameter int    LAYER_NO    = 1,
    parameter int    NEURON_NO   = 0,
    parameter int    WEIGHT_NUM  = 784,
    parameter int    LANES       = 4,
    parameter int    DATA_WIDTH  = 16,
    parameter int    INT_WIDTH   = 4,
    parameter string ACT_TYPE    = "relu",
    parameter int    LEAKY_SHIFT = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [LANES*DATA_WIDTH-1:0] in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_WIDTH-1:0]       weight_value,
    input  logic                        weight_valid,
    input  logic [DATA_WIDTH-1:0]       bias_value,
    input  logic                        bias_valid,
    input  logic [31:0]                 config_layer_num,
    input  logic [31:0]                 config_neuron_num,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        busy
);
    localparam int DW      = DATA_WIDTH;
    localparam int FRAC    = DW - INT_WIDTH;
    localparam int ROWS    = WEIGHT_NUM / LANES;
    localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int BW      = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int AW      = 2*DW + $clog2(WEIGHT_NUM);
    localparam int ACT_SEL = (ACT_TYPE == "linear") ? 1 : (ACT_TYPE == "leaky") ? 2 : 0;
    localparam logic signed [AW:0] SAT_HI = (AW+1)'(2**(DW-1) - 1);
    localparam logic signed [AW:0] SAT_LO = (AW+1)'(-(2**(DW-1)));

    typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, BIAS, OUT} state_t;
    state_t state, state_nxt;

    logic [RW-1:0]          beat_cnt, beat_nxt;
    logic                   drain_cnt;
    logic                   accept, last_beat, cfg_match, w_en, b_en, out_hs;
    logic [BW-1:0]          wbank;
    logic [RW-1:0]          wrow;
    logic signed [DW-1:0]   bias_q;
    logic [DW-1:0]          mem [LANES][ROWS];
    logic signed [DW-1:0]   rd_w [LANES];
    logic signed [2*DW-1:0] mult;
    logic signed [2*DW-1:0] prod_c [LANES];
    logic signed [2*DW-1:0] prod_q [LANES];
    logic                   prod_vld;
    logic signed [AW-1:0]   acc, lane_sum;
    logic signed [AW:0]     s_full;
    logic signed [DW-1:0]   sat, sat_q, act;

    assign busy      = (state != IDLE);
    assign in_ready  = (state == IDLE) || (state == ACCUM);
    assign out_valid = (state == OUT);
    assign accept    = in_valid && in_ready;
    assign last_beat = accept && (beat_cnt == RW'(ROWS-1));
    assign out_hs    = out_valid && out_ready;
    assign cfg_match = (config_layer_num == 32'(LAYER_NO)) && (config_neuron_num == 32'(NEURON_NO));
    assign w_en      = weight_valid && !busy && cfg_match;
    assign b_en      = bias_valid && !busy && cfg_match;

    // The RAM is read with the row of the *next* beat, so the weights for a beat
    // are already sitting in rd_w in the cycle that beat is accepted.
    always_comb begin
        beat_nxt = beat_cnt;
        if (last_beat)
            beat_nxt = '0;
        else if (accept)
            beat_nxt = beat_cnt + RW'(1);
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = last_beat ? DRAIN : ACCUM;
            ACCUM:   if (last_beat) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt) state_nxt = BIAS;
            BIAS:    state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operands are widened before multiplying so the full product is kept, then floored.
    always_comb begin
        mult   = '0;
        prod_c = '{default: '0};
        for (int k = 0; k < LANES; k++) begin
            mult      = (2*DW)'($signed(in_data[k*DW +: DW])) * (2*DW)'(rd_w[k]);
            prod_c[k] = mult >>> FRAC;
        end
    end

    always_comb begin
        lane_sum = '0;
        for (int k = 0; k < LANES; k++)
            lane_sum = lane_sum + AW'(prod_q[k]);
    end

    always_comb begin
        s_full = (AW+1)'(acc) + (AW+1)'(bias_q);
        if (s_full > SAT_HI)
            sat = {1'b0, {(DW-1){1'b1}}};
        else if (s_full < SAT_LO)
            sat = {1'b1, {(DW-1){1'b0}}};
        else
            sat = s_full[DW-1:0];
    end

    always_comb begin
        act = sat_q;
        if (ACT_SEL == 0 && sat_q[DW-1])
            act = '0;
        else if (ACT_SEL == 2 && sat_q[DW-1])
            act = sat_q >>> LEAKY_SHIFT;
    end

    // Weight RAM: one bank per lane, no reset. A write landing on the row being
    // prefetched is forwarded so a load just before a vector is not missed.
    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (w_en && (wbank == BW'(k)))
                mem[k][wrow] <= weight_value;
            if (w_en && (wbank == BW'(k)) && (wrow == beat_nxt))
                rd_w[k] <= weight_value;
            else
                rd_w[k] <= mem[k][beat_nxt];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            drain_cnt <= 1'b0;
            wbank     <= '0;
            wrow      <= '0;
            bias_q    <= '0;
            prod_vld  <= 1'b0;
            prod_q    <= '{default: '0};
            acc       <= '0;
            sat_q     <= '0;
            out_data  <= '0;
        end else begin
            state     <= state_nxt;
            beat_cnt  <= out_hs ? '0 : beat_nxt;
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
            if (w_en) begin
                if (wbank == BW'(LANES-1)) begin
                    wbank <= '0;
                    wrow  <= (wrow == RW'(ROWS-1)) ? '0 : wrow + RW'(1);
                end else begin
                    wbank <= wbank + BW'(1);
                end
            end
            if (b_en)
                bias_q <= bias_value;
            prod_vld <= accept;
            if (accept)
                prod_q <= prod_c;
            if (out_hs)
                acc <= '0;
            else if (prod_vld)
                acc <= acc + lane_sum;
            sat_q <= sat;
            if (state == BIAS)
                out_data <= act;
        end
    end
endmodule

// File: doc/neuron_lane_mac.md
# neuron_lane_mac

Parametrised, multi-lane successor to the serial neuron: computes one fixed-point dot product of a WEIGHT_NUM-element input vector against a runtime-loaded weight memory, LANES elements per beat, then adds a bias, saturates and applies a selectable activation. It sits in a layer array (one instance per neuron), addressed for weight/bias loading by layer/neuron number, with valid/ready handshakes on the data input and output.

## Interface
- LAYER_NO, 1, layer number matched against config_layer_num
- NEURON_NO, 0, neuron number matched against config_neuron_num
- WEIGHT_NUM, 784, weights per neuron; must be a multiple of LANES
- LANES, 4, input elements consumed per beat
- DATA_WIDTH, 16, signed width of inputs, weights, bias, output
- INT_WIDTH, 4, integer bits incl. sign; FRAC = DATA_WIDTH-INT_WIDTH
- ACT_TYPE, "relu", one of "relu", "linear", "leaky"
- LEAKY_SHIFT, 3, right-shift applied to negatives in "leaky"
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_data  in  LANES*DATA_WIDTH  lane k at bits [k*DW +: DW], element index beat*LANES+k
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid&in_ready
- weight_value  in  DATA_WIDTH  weight write data
- weight_valid  in  1  weight write strobe
- bias_value  in  DATA_WIDTH  bias write data
- bias_valid  in  1  bias write strobe
- config_layer_num  in  32  target layer for weight/bias writes
- config_neuron_num  in  32  target neuron for weight/bias writes
- out_data  out  DATA_WIDTH  activated result
- out_valid  out  1  result valid; held until out_ready
- out_ready  in  1  downstream accept
- busy  out  1  high from first accepted beat until output handshake

## Operation
- Weight load: write accepted when weight_valid, busy=0, config_layer_num==LAYER_NO, config_neuron_num==NEURON_NO. Writes to address wptr (bank wptr%LANES, row wptr/LANES); wptr increments, wraps WEIGHT_NUM-1 -> 0. Writes with busy=1 or mismatched config are dropped, wptr unchanged.
- Bias load: same match/busy rule; bias register <= bias_value.
- FSM: IDLE -> ACCUM on first accepted beat; ACCUM -> DRAIN after beat WEIGHT_NUM/LANES-1 accepted; DRAIN (2 cycles, pipeline flush) -> BIAS -> OUT; OUT -> IDLE on out_valid&out_ready.
- in_ready = 1 in IDLE and ACCUM, 0 otherwise. Beat counter resets to 0 on IDLE entry.
- Per beat: synchronous RAM read of row = beat counter; products p_k = (x_k*w_k) >>> FRAC (arithmetic, floor); lane sum added to accumulator of width 2*DATA_WIDTH+clog2(WEIGHT_NUM). Accumulator cleared on IDLE entry.
- BIAS: s = acc + sign-extended bias; saturate to [-2^(DW-1), 2^(DW-1)-1].
- Activation on saturated s: relu: s<0 -> 0; linear: s; leaky: s<0 -> s>>>LEAKY_SHIFT.
- Weight RAM and bias not cleared by reset semantics for RAM; bias and wptr reset to 0.

## Timing
- Reset values: in_ready 1, out_valid 0, out_data 0, busy 0; FSM IDLE, wptr 0, bias 0, accumulator 0.
- Last beat accepted at cycle T: products registered T+1, accumulator T+2, bias/saturate T+3, out_valid=1 with out_data at T+4.
- Beats may have bubbles (in_valid low); accumulation advances only on accepted beats.
- out_valid, out_data stable until out_ready; IDLE (in_ready=1) the cycle after the handshake; no input accepted same cycle as handshake.
- in_valid while in_ready=0: ignored, no state change.
- Reset asserted mid-vector: all state to reset values immediately; weights retained; next vector computes from zero.
- Weight write and bias write in same cycle: both take effect.

## Test plan
- DW=16, INT=4, WEIGHT_NUM=8, LANES=4; load 8 weights 0x1000, bias 0; two beats all lanes 0x0100 -> out_data 0x0800, out_valid exactly 4 cycles after second beat.
- Same weights, inputs 0xFF00 (-1/16): relu -> 0x0000; linear -> 0xF800; leaky -> 0xFF00; with bias 0x1000 relu -> 0x0800.
- All weights and inputs 0x7FFF, bias 0x7FFF -> out_data saturates to 0x7FFF; all inputs 0x8000, linear -> 0x8000.
- Weight writes with config_neuron_num != NEURON_NO -> weights unchanged; 9 matched writes -> 9th overwrites address 0 (wrap); writes while busy=1 dropped.
- Hold out_ready=0 for 5 cycles with in_valid=1 -> out_valid/out_data held, in_ready=0, no beat accepted; first beat accepted cycle after handshake.
- Assert rst_n low after 1 of 2 beats -> outputs at reset values; full vector afterwards yields 0x0800 with previously loaded weights.
